// File: rtl/diferential_rv_b4_if.sv
// Top-level tile bus for diferential_rv_b4: 8-bit input bus (clk, rst, unused bits)
// and 8-bit output bus (7-segment drive plus decimal point).
interface diferential_rv_b4_if;
   logic [7:0] io_in;
   logic [7:0] io_out;

   modport master (
      output io_in,
      input  io_out
   );

   modport slave (
      input  io_in,
      output io_out
   );
endinterface

// File: rtl/diferential_rv_b4.sv
// diferential_rv_b4: 4-bit ADD datapath stepping two registers through the Fibonacci
// sequence mod 16. The newest value is shown on a 7-segment display, and the carry
// drives the decimal point.
// Optional feature macro: FAST_STEP_EN. When it is defined, the prescaler is removed
// and every non-reset edge performs a step.
module diferential_rv_b4 #(
   parameter int unsigned STEP_LOG2 = 10
) (
   diferential_rv_b4_if.slave bus
);

   logic       clk;
   logic       rst;
   logic       step;
   logic [3:0] ra;
   logic [3:0] rb;
   logic       cy;
   logic [4:0] sum;
   logic [6:0] seg;
   logic       unused_in;

   assign clk       = bus.io_in[0];
   assign rst       = bus.io_in[1];
   assign unused_in = ^bus.io_in[7:2];

`ifdef FAST_STEP_EN
   assign step = 1'b1;
`else
   logic [STEP_LOG2-1:0] pre;

   // Free-running prescaler; it restarts from zero on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre <= '0;
      end else begin
         pre <= pre + STEP_LOG2'(1);
      end
   end

   assign step = (pre == '1);
`endif

   assign sum = {1'b0, ra} + {1'b0, rb};

   // Datapath registers; reset takes priority over the step strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         ra <= 4'h0;
         rb <= 4'h1;
         cy <= 1'b0;
      end else if (step) begin
         ra <= rb;
         rb <= sum[3:0];
         cy <= sum[4];
      end
   end

   // Hex-to-7-segment decode of rb (bit0 = a ... bit6 = g).
   always_comb begin
      seg = 7'h00;
      unique case (rb)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         4'hF: seg = 7'h71;
         default: seg = 7'h00;
      endcase
   end

   assign bus.io_out = {cy, seg};

endmodule

// File: tb/tb_diferential_rv_b4.sv
// Testbench for diferential_rv_b4. Adapts its step period to the FAST_STEP_EN build.
module tb_diferential_rv_b4;

`ifdef FAST_STEP_EN
   localparam int STEP = 1;
`else
   localparam int STEP = 1024;
`endif

   logic       clk;
   logic       rst;
   logic [5:0] junk;
   int         n_tests;
   int         n_fail;
   int         idx;

   // Golden rb for step index mod 24, and carry after that step.
   logic [3:0] rb_gold [24] = '{4'h1, 4'h1, 4'h2, 4'h3, 4'h5, 4'h8, 4'hD, 4'h5,
                                4'h2, 4'h7, 4'h9, 4'h0, 4'h9, 4'h9, 4'h2, 4'hB,
                                4'hD, 4'h8, 4'h5, 4'hD, 4'h2, 4'hF, 4'h1, 4'h0};
   logic       cy_gold [24] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                                1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
   logic [6:0] seg_gold [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   diferential_rv_b4_if bus ();

   assign bus.io_in = {junk, rst, clk};

   diferential_rv_b4 dut (
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it if observed differs from expected.
   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance one rising edge and settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] expected(input int i);
      int k;
      k = i % 24;
      return {cy_gold[k], seg_gold[rb_gold[k]]};
   endfunction

   // Run n full steps, scrambling the ignored inputs and checking every edge.
   task automatic run_steps(input int n);
      for (int e = 1; e <= n * STEP; e++) begin
         tick();
         junk = 6'($urandom);
         if (e % STEP == 0) idx++;
         check_eq("seq", bus.io_out, expected(idx));
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      idx     = 0;
      rst     = 1'b1;
      junk    = 6'h0;

      // Reset held for two edges.
      tick();
      check_eq("reset_1", bus.io_out, 8'h06);
      tick();
      check_eq("reset_2", bus.io_out, 8'h06);
      rst = 1'b0;

      run_steps(7);
      check_eq("step7", bus.io_out, 8'hED);
      run_steps(4);
      check_eq("step11", bus.io_out, 8'hBF);
      run_steps(13);
      check_eq("wrap24", bus.io_out, 8'h06);
      run_steps(24);
      check_eq("wrap48", bus.io_out, 8'h06);
      run_steps(9);
      check_eq("before_rst", bus.io_out, 8'h07);

      // Mid-run reset for one edge.
      rst = 1'b1;
      tick();
      check_eq("midrst", bus.io_out, 8'h06);
      rst = 1'b0;
      idx = 0;
      run_steps(1);
      check_eq("post_rst_s1", bus.io_out, 8'h06);
      run_steps(1);
      check_eq("post_rst_s2", bus.io_out, 8'h5B);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
